// File: rtl/masked_subbytes_sequencer_pkg.sv
// Shared types and helpers for the byte-serial masked SubBytes/ShiftRows sequencer.
// A state holds 16 bytes; byte k sits in row k%4 and column k/4.
package masked_subbytes_sequencer_pkg;

   typedef logic [7:0] bv8_t;
   typedef bv8_t [15:0] state_t;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_FEED  = 2'd1,
      SEQ_DRAIN = 2'd2
   } subbytes_seq_state_t;

   localparam logic [3:0] LAST_IDX = 4'd15;

   // ShiftRows destination of source byte k: the row is kept and the column becomes (c - r) mod 4.
   function automatic logic [3:0] shift_rows_pos(input logic [3:0] k);
      logic [1:0] col_s;
      col_s = k[3:2] - k[1:0];
      return {col_s, k[1:0]};
   endfunction

endpackage

// File: rtl/masked_state_slot_tracker.sv
// Delay line of {valid, byte index} tags that runs alongside the external S-box pipeline,
// so each S-box result can be matched to the state byte it came from.
module masked_state_slot_tracker #(
   parameter int LATENCY = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_valid_i,
   input  logic [3:0] push_idx_i,
   output logic       pop_valid_o,
   output logic [3:0] pop_idx_o
);

   logic [LATENCY-1:0]      vld_q;
   logic [LATENCY-1:0]      vld_d;
   logic [LATENCY-1:0][3:0] idx_q;
   logic [LATENCY-1:0][3:0] idx_d;

   // Shift every tag one stage forward and load the new tag into stage 0.
   always_comb begin
      vld_d    = vld_q;
      idx_d    = idx_q;
      vld_d[0] = push_valid_i;
      idx_d[0] = push_idx_i;
      for (int i = 1; i < LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         idx_d[i] = idx_q[i-1];
      end
   end

   // Tag register; reset invalidates every in-flight tag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= '0;
         idx_q <= '0;
      end else begin
         vld_q <= vld_d;
         idx_q <= idx_d;
      end
   end

   assign pop_valid_o = vld_q[LATENCY-1];
   assign pop_idx_o   = idx_q[LATENCY-1];

endmodule

// File: rtl/masked_subbytes_sequencer.sv
// Streams a captured 16-byte shared state one byte per cycle through an external masked S-box
// and collects the results into the output state, optionally scattered through ShiftRows.
module masked_subbytes_sequencer
   import masked_subbytes_sequencer_pkg::*;
#(
   parameter int NUM_SHARES       = 2,
   parameter int LATENCY          = 3,
   parameter int APPLY_SHIFT_ROWS = 1
) (
   input  logic                    in_clock,
   input  logic                    in_reset,
   input  logic                    in_start,
   input  state_t [NUM_SHARES-1:0] in_state,
   output bv8_t   [NUM_SHARES-1:0] out_sbox_in,
   input  bv8_t   [NUM_SHARES-1:0] in_sbox_out,
   output state_t [NUM_SHARES-1:0] out_state,
   output logic                    out_busy,
   output logic                    out_done
);

   subbytes_seq_state_t     state_q, state_d;
   state_t [NUM_SHARES-1:0] src_q, src_d;
   state_t [NUM_SHARES-1:0] result_q, result_d;
   bv8_t   [NUM_SHARES-1:0] sbox_in_q, sbox_in_d;
   logic   [3:0]            rd_idx_q, rd_idx_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic                    push_valid_s;
   logic                    pop_valid_s;
   logic   [3:0]            pop_idx_s;
   logic   [3:0]            wr_pos_s;

   assign push_valid_s = (state_q == SEQ_FEED);
   assign wr_pos_s     = (APPLY_SHIFT_ROWS != 0) ? shift_rows_pos(pop_idx_s) : pop_idx_s;

   masked_state_slot_tracker #(
      .LATENCY (LATENCY)
   ) u_tracker (
      .clk_i        (in_clock),
      .rst_i        (in_reset),
      .push_valid_i (push_valid_s),
      .push_idx_i   (rd_idx_q),
      .pop_valid_o  (pop_valid_s),
      .pop_idx_o    (pop_idx_s)
   );

   // Sequencing, feed-byte selection and result write-back.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      result_d  = result_q;
      sbox_in_d = '0;
      rd_idx_d  = rd_idx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         SEQ_IDLE: begin
            if (in_start) begin
               state_d  = SEQ_FEED;
               src_d    = in_state;
               rd_idx_d = 4'd0;
               busy_d   = 1'b1;
               for (int s = 0; s < NUM_SHARES; s++) begin
                  sbox_in_d[s] = in_state[s][0];
               end
            end else begin
               state_d = SEQ_IDLE;
            end
         end
         SEQ_FEED: begin
            if (rd_idx_q == LAST_IDX) begin
               state_d  = SEQ_DRAIN;
               rd_idx_d = 4'd0;
            end else begin
               rd_idx_d = rd_idx_q + 4'd1;
               for (int s = 0; s < NUM_SHARES; s++) begin
                  sbox_in_d[s] = src_q[s][rd_idx_q + 4'd1];
               end
            end
         end
         SEQ_DRAIN: begin
            // Byte 15 is always the youngest tag, so its exit empties the pipe.
            if (pop_valid_s && (pop_idx_s == LAST_IDX)) begin
               state_d = SEQ_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = SEQ_DRAIN;
            end
         end
         default: begin
            state_d = SEQ_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (pop_valid_s) begin
         for (int s = 0; s < NUM_SHARES; s++) begin
            result_d[s][wr_pos_s] = in_sbox_out[s];
         end
      end else begin
         result_d = result_q;
      end
   end

   // State registers; the feed byte is registered so the S-box sees a glitch-free input.
   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         state_q   <= SEQ_IDLE;
         src_q     <= '0;
         result_q  <= '0;
         sbox_in_q <= '0;
         rd_idx_q  <= 4'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         result_q  <= result_d;
         sbox_in_q <= sbox_in_d;
         rd_idx_q  <= rd_idx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign out_sbox_in = sbox_in_q;
   assign out_state   = result_q;
   assign out_busy    = busy_q;
   assign out_done    = done_q;

endmodule

// File: tb/tb_masked_subbytes_sequencer.sv
// Scoreboard bench: five sequencer configurations share one stimulus stream, each with its own
// masked S-box model, expected-result queue and output monitor.
module tb_masked_subbytes_sequencer;
   import masked_subbytes_sequencer_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   state_t [1:0] in_state;
   state_t       exp_sr;
   state_t       exp_id;
   int           n_vec  = 0;
   int           n_miss = 0;
   event         end_ev;

   always #5 clk = ~clk;

   // Byte 0 is the least significant byte of each constant.
   localparam state_t FIPS_IN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
   localparam state_t FIPS_SR  = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;
   localparam state_t FIPS_ID  = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
   localparam state_t ALL_63   = {16{8'h63}};

   function automatic bv8_t gmul(input bv8_t a, input bv8_t b);
      bv8_t p = 8'h00;
      bv8_t x = a;
      bv8_t y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic bv8_t rotl(input bv8_t v, input int n);
      bv8_t a = v << n;
      bv8_t b = v >> (8 - n);
      return a | b;
   endfunction

   function automatic bv8_t aes_sbox(input bv8_t a);
      bv8_t r  = 8'h01;
      bv8_t sq = a;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
   endfunction

   function automatic state_t sub_state(input state_t x);
      state_t o;
      for (int k = 0; k < 16; k++) o[k] = aes_sbox(x[k]);
      return o;
   endfunction

   function automatic state_t shift_rows(input state_t s);
      state_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[r + 4*c] = s[r + 4*((c + r) % 4)];
      return o;
   endfunction

   function automatic state_t recomb(input state_t [1:0] s);
      return s[0] ^ s[1];
   endfunction

   task automatic check(input string name, input int inst, input logic [127:0] act,
                        input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s cfg%0d: got %h expected %h", name, inst, act, exp);
      end
   endtask

   task automatic set_input(input state_t x, input bit masked, input state_t e_sr,
                            input state_t e_id);
      state_t m;
      for (int k = 0; k < 16; k++) m[k] = masked ? 8'($urandom) : 8'h00;
      in_state[0] = m;
      in_state[1] = x ^ m;
      exp_sr      = e_sr;
      exp_id      = e_id;
   endtask

   task automatic launch(input state_t x, input bit masked, input state_t e_sr,
                         input state_t e_id);
      set_input(x, masked, e_sr, e_id);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   for (genvar g = 0; g < 5; g++) begin : gen_cfg
      localparam int LAT = (g == 2) ? 1 : (g == 3) ? 2 : (g == 4) ? 4 : 3;
      localparam int SR  = (g == 1) ? 0 : 1;

      bv8_t   [1:0] sbox_in_s;
      bv8_t   [1:0] sbox_out_s;
      state_t [1:0] out_state_s;
      logic         busy_s;
      logic         done_s;
      bv8_t   [1:0] sb_pipe [LAT];
      int           cyc_m    = 0;
      bit           armed    = 1'b0;
      bit           zero_chk = 1'b0;
      state_t       exp_q [$];

      masked_subbytes_sequencer #(
         .NUM_SHARES       (2),
         .LATENCY          (LAT),
         .APPLY_SHIFT_ROWS (SR)
      ) u_dut (
         .in_clock    (clk),
         .in_reset    (rst),
         .in_start    (start),
         .in_state    (in_state),
         .out_sbox_in (sbox_in_s),
         .in_sbox_out (sbox_out_s),
         .out_state   (out_state_s),
         .out_busy    (busy_s),
         .out_done    (done_s)
      );

      // Masked S-box model: fresh output mask each cycle, LAT register stages.
      always @(posedge clk) begin
         bv8_t m;
         m = 8'($urandom);
         sb_pipe[0] <= {m, aes_sbox(sbox_in_s[0] ^ sbox_in_s[1]) ^ m};
         for (int i = 1; i < LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
      end
      assign sbox_out_s = sb_pipe[LAT-1];

      // Cycle model: cyc_m is the cycle number since the accepted start, 0 when idle.
      always @(posedge clk) begin
         if (rst) begin
            cyc_m    = 0;
            armed    = 1'b1;
            zero_chk = 1'b1;
            exp_q.delete();
         end else begin
            zero_chk = 1'b0;
            if ((cyc_m == 0 || cyc_m == 17 + LAT) && start) begin
               cyc_m = 1;
               exp_q.push_back((SR != 0) ? exp_sr : exp_id);
            end else if (cyc_m >= 1 && cyc_m <= 16 + LAT) begin
               cyc_m = cyc_m + 1;
            end else begin
               cyc_m = 0;
            end
         end
      end

      always @(negedge clk) begin
         if (armed) begin
            check("busy", g, 128'(busy_s), 128'(cyc_m >= 1 && cyc_m <= 16 + LAT));
            check("done", g, 128'(done_s), 128'(cyc_m == 17 + LAT));
            if (!(cyc_m >= 1 && cyc_m <= 16))
               check("sbox_in_idle", g, 128'(sbox_in_s), 128'd0);
            if (zero_chk) begin
               check("reset_share0", g, out_state_s[0], 128'd0);
               check("reset_share1", g, out_state_s[1], 128'd0);
            end
            if (done_s === 1'b1) begin
               check("pending", g, 128'(exp_q.size() != 0), 128'd1);
               if (exp_q.size() != 0)
                  check("result", g, recomb(out_state_s), exp_q.pop_front());
            end
         end
      end

      initial begin
         @(end_ev);
         check("leftover", g, 128'(exp_q.size()), 128'd0);
      end
   end

   initial begin
      state_t x;
      rst      = 1'b1;
      start    = 1'b0;
      in_state = '0;
      exp_sr   = '0;
      exp_id   = '0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // All-zero shares: every recombined output byte is S(0) = 0x63.
      launch('0, 1'b0, ALL_63, ALL_63);
      repeat (30) @(negedge clk);

      // FIPS-197 round-1 SubBytes/ShiftRows with random shares.
      launch(FIPS_IN, 1'b1, FIPS_SR, FIPS_ID);
      repeat (30) @(negedge clk);

      // Start held high; input changes every cycle so an ignored start would show up.
      start = 1'b1;
      for (int n = 0; n < 62; n++) begin
         for (int k = 0; k < 16; k++) x[k] = 8'($urandom);
         set_input(x, 1'b1, shift_rows(sub_state(x)), sub_state(x));
         @(negedge clk);
      end
      start = 1'b0;
      repeat (30) @(negedge clk);

      // Reset in cycle 8 after start discards the operation.
      launch(FIPS_IN, 1'b1, FIPS_SR, FIPS_ID);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);

      // Fresh run after the abort.
      launch(FIPS_IN, 1'b1, FIPS_SR, FIPS_ID);
      repeat (30) @(negedge clk);

      -> end_ev;
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
